// File: rtl/umai_pkg.sv
// Shared UMAI definitions for the on-chip memory responder.
// Holds the UMAI field widths, the responder FSM state type and the
// round-robin flag encoding used by umai_mem_responder.
package umai_pkg;

  localparam int UMAI_ADDR_W     = 32;
  localparam int UMAI_LEN_W      = 6;
  localparam int UMAI_DATA_W     = 512;
  localparam int UMAI_BEAT_BYTES = 64;

  // Round-robin flag: which command type was granted most recently.
  localparam logic RR_WRITE = 1'b0;
  localparam logic RR_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } umai_resp_state_e;

endpackage

// File: rtl/umai_resp_mem.sv
// Local beat storage for umai_mem_responder: DEPTH x 512-bit flop array with
// one synchronous write port and one combinational read port. Contents are
// not reset. Kept as its own module so it can be swapped for an SRAM macro.
module umai_resp_mem
  import umai_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UMAI_DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UMAI_DATA_W-1:0] o_rdata
);

  logic [UMAI_DATA_W-1:0] mem_q [DEPTH];

  // Store one beat per enabled clock edge.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/umai_mem_responder.sv
// UMAI target terminating an aib_top UMAI master port on-chip. Write bursts
// are stored in a local memory and read bursts are returned from it, one
// command outstanding at a time, with write/read ties broken round-robin.
// Optional build macro UMAI_MEM_RESPONDER_STATS_EN adds 32-bit counters of
// accepted write and read data beats.
module umai_mem_responder
  import umai_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
`ifdef UMAI_MEM_RESPONDER_STATS_EN
  output logic [31:0]            o_wr_beat_cnt,
  output logic [31:0]            o_rd_beat_cnt,
`endif
  input  logic                   i_wcmd_valid,
  output logic                   o_wcmd_ready,
  input  logic [UMAI_ADDR_W-1:0] i_wcmd_addr,
  input  logic [UMAI_LEN_W-1:0]  i_wcmd_len,
  input  logic                   i_rcmd_valid,
  output logic                   o_rcmd_ready,
  input  logic [UMAI_ADDR_W-1:0] i_rcmd_addr,
  input  logic [UMAI_LEN_W-1:0]  i_rcmd_len,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  input  logic [UMAI_DATA_W-1:0] i_wdata,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  output logic [UMAI_DATA_W-1:0] o_rdata
);

  umai_resp_state_e       state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [UMAI_LEN_W-1:0]  beats_q, beats_d;
  logic                   rr_last_q, rr_last_d;
  logic                   rvalid_q, rvalid_d;
  logic [UMAI_DATA_W-1:0] rdata_q, rdata_d;

  logic                   grant_w, grant_r;
  logic                   wbeat, rbeat;
  logic [AW-1:0]          wstart, rstart, idx_inc, mem_raddr;
  logic [UMAI_DATA_W-1:0] mem_rdata;
  logic                   unused_addr_bits;

  // Byte offset and bits above the memory size are dropped (aliasing).
  assign wstart           = i_wcmd_addr[AW+5:6];
  assign rstart           = i_rcmd_addr[AW+5:6];
  assign unused_addr_bits = ^{i_wcmd_addr, i_rcmd_addr};

  assign idx_inc = idx_q + AW'(1);
  assign wbeat   = (state_q == WR) && i_wvalid;
  assign rbeat   = (state_q == RD) && rvalid_q && i_rready;

  // In IDLE the read port looks at the requested start word so the first
  // beat can be registered on the handshake edge; in RD it prefetches the
  // following word so accepted beats are replaced without a bubble.
  assign mem_raddr = (state_q == RD) ? idx_inc : rstart;

  umai_resp_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (wbeat),
    .i_waddr (idx_q),
    .i_wdata (i_wdata),
    .i_raddr (mem_raddr),
    .o_rdata (mem_rdata)
  );

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a burst returns to IDLE on its last accepted beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_w)      state_d = WR;
        else if (grant_r) state_d = RD;
      end
      WR:      if (wbeat && (beats_q == '0)) state_d = IDLE;
      RD:      if (rbeat && (beats_q == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: command grants (round-robin on a tie) and write-data ready.
  always_comb begin
    grant_w = 1'b0;
    grant_r = 1'b0;
    if ((state_q == IDLE) && !i_rst) begin
      grant_w = i_wcmd_valid && (!i_rcmd_valid || (rr_last_q == RR_READ));
      grant_r = i_rcmd_valid && (!i_wcmd_valid || (rr_last_q == RR_WRITE));
    end
    o_wcmd_ready = grant_w;
    o_rcmd_ready = grant_r;
    o_wready     = (state_q == WR);
  end

  // Burst bookkeeping and read-data register next values.
  always_comb begin
    idx_d     = idx_q;
    beats_d   = beats_q;
    rr_last_d = rr_last_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (grant_w) begin
      idx_d     = wstart;
      beats_d   = i_wcmd_len;
      rr_last_d = RR_WRITE;
    end else if (grant_r) begin
      idx_d     = rstart;
      beats_d   = i_rcmd_len;
      rr_last_d = RR_READ;
      rvalid_d  = 1'b1;
      rdata_d   = mem_rdata;
    end
    if (wbeat) begin
      idx_d   = idx_inc;
      beats_d = beats_q - 1'b1;
    end
    if (rbeat) begin
      if (beats_q == '0) begin
        rvalid_d = 1'b0;
      end else begin
        rdata_d = mem_rdata;
        idx_d   = idx_inc;
        beats_d = beats_q - 1'b1;
      end
    end
  end

  // Burst bookkeeping and read-data registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx_q     <= '0;
      beats_q   <= '0;
      rr_last_q <= RR_READ;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      idx_q     <= idx_d;
      beats_q   <= beats_d;
      rr_last_q <= rr_last_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;

`ifdef UMAI_MEM_RESPONDER_STATS_EN
  logic [31:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  assign wr_cnt_d = wr_cnt_q + 32'(wbeat);
  assign rd_cnt_d = rd_cnt_q + 32'(rbeat);

  // Free-running accepted-beat counters, wrapping at 2^32.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign o_wr_beat_cnt = wr_cnt_q;
  assign o_rd_beat_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_umai_mem_responder.sv
// Self-checking bench for umai_mem_responder (DEPTH = 64). Keeps a word-array
// model of the memory indexed by (byte address / 64 + beat) mod DEPTH.
module tb_umai_mem_responder;
  import umai_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic         clk;
  logic         i_rst;
  logic         i_wcmd_valid, o_wcmd_ready;
  logic [31:0]  i_wcmd_addr;
  logic [5:0]   i_wcmd_len;
  logic         i_rcmd_valid, o_rcmd_ready;
  logic [31:0]  i_rcmd_addr;
  logic [5:0]   i_rcmd_len;
  logic         i_wvalid, o_wready;
  logic [511:0] i_wdata;
  logic         o_rvalid, i_rready;
  logic [511:0] o_rdata;
`ifdef UMAI_MEM_RESPONDER_STATS_EN
  logic [31:0]  o_wr_beat_cnt, o_rd_beat_cnt;
`endif

  umai_mem_responder #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
`ifdef UMAI_MEM_RESPONDER_STATS_EN
    .o_wr_beat_cnt (o_wr_beat_cnt),
    .o_rd_beat_cnt (o_rd_beat_cnt),
`endif
    .i_wcmd_valid  (i_wcmd_valid),
    .o_wcmd_ready  (o_wcmd_ready),
    .i_wcmd_addr   (i_wcmd_addr),
    .i_wcmd_len    (i_wcmd_len),
    .i_rcmd_valid  (i_rcmd_valid),
    .o_rcmd_ready  (o_rcmd_ready),
    .i_rcmd_addr   (i_rcmd_addr),
    .i_rcmd_len    (i_rcmd_len),
    .i_wvalid      (i_wvalid),
    .o_wready      (o_wready),
    .i_wdata       (i_wdata),
    .o_rvalid      (o_rvalid),
    .i_rready      (i_rready),
    .o_rdata       (o_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [511:0] mem_m [DEPTH];
  int           wr_cnt_m = 0;
  int           rd_cnt_m = 0;
  bit           stall_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  len;
    logic [31:0] pat;
    int          exp_word;
  } vec_t;
  vec_t tbl [5];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] widx(input int w);
    return AW'(w % DEPTH);
  endfunction

  function automatic int addr_word(input logic [31:0] a);
    return int'((a / 32'd64) % 32'(DEPTH));
  endfunction

  function automatic logic [511:0] pat_beat(input logic [31:0] p, input int i);
    return {16{p + 32'(i)}};
  endfunction

  function automatic logic [511:0] rand_beat();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Asynchronous reset pulse: outputs must clear at once, before any edge.
  task automatic pulse_reset();
    i_rst = 1'b1;
    #1;
    check1("rst_wcmd_ready", o_wcmd_ready, 1'b0);
    check1("rst_rcmd_ready", o_rcmd_ready, 1'b0);
    check1("rst_wready", o_wready, 1'b0);
    check1("rst_rvalid", o_rvalid, 1'b0);
    checkw("rst_rdata", o_rdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    wr_cnt_m = 0;
    rd_cnt_m = 0;
  endtask

  // Present one command and wait (bounded) for its grant; returns #1 after
  // the handshake edge with the valid dropped.
  task automatic issue_cmd(input bit is_wr, input logic [31:0] addr, input logic [5:0] len,
                           output bit ok);
    @(negedge clk);
    if (is_wr) begin
      i_wcmd_valid = 1'b1; i_wcmd_addr = addr; i_wcmd_len = len;
    end else begin
      i_rcmd_valid = 1'b1; i_rcmd_addr = addr; i_rcmd_len = len;
    end
    #1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if ((is_wr ? o_wcmd_ready : o_rcmd_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) begin
      check1("cmd_grant_timeout", 1'b0, 1'b1);
    end else if (is_wr) begin
      check1("rcmd_ready_excl", o_rcmd_ready, 1'b0);
    end else begin
      check1("wcmd_ready_excl", o_wcmd_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    i_wcmd_valid = 1'b0;
    i_rcmd_valid = 1'b0;
    i_wcmd_addr  = $urandom;
    i_rcmd_addr  = $urandom;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [5:0] len, input int start_w,
                             input bit rnd, input logic [31:0] pat, input bit gaps);
    bit ok;
    logic [511:0] d;
    issue_cmd(1'b1, addr, len, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          i_wvalid = 1'b0;
          i_wdata  = rand_beat();
          @(negedge clk);
          check1("wready_gap", o_wready, 1'b1);
          @(posedge clk);
          #1;
        end
      end
      d = rnd ? rand_beat() : pat_beat(pat, i);
      i_wvalid = 1'b1;
      i_wdata  = d;
      @(negedge clk);
      check1("wready", o_wready, 1'b1);
      @(posedge clk);
      #1;
      mem_m[widx(start_w + i)] = d;
      wr_cnt_m++;
    end
    i_wvalid = 1'b0;
    @(negedge clk);
    check1("wready_after_burst", o_wready, 1'b0);
  endtask

  // Collect a read burst whose command handshake has just happened.
  // mode 0: always ready, 1: random ready, 2: scripted 1,0,0,1,1 then ready.
  task automatic collect_read(input int start_w, input logic [5:0] len, input int mode);
    int got = 0;
    int cyc = 0;
    bit rr;
    while (got <= int'(len) && cyc < 400) begin
      @(negedge clk);
      check1("rvalid", o_rvalid, 1'b1);
      checkw("rdata", o_rdata, mem_m[widx(start_w + got)]);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(0, 1));
        default: rr = (cyc < 5) ? stall_pat[cyc] : 1'b1;
      endcase
      i_rready = rr;
      if ((o_rvalid === 1'b1) && rr) begin
        got++;
        rd_cnt_m++;
      end
      cyc++;
    end
    if (got <= int'(len)) check1("read_beats_timeout", 1'b0, 1'b1);
    @(negedge clk);
    check1("rvalid_after_burst", o_rvalid, 1'b0);
    i_rready = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [5:0] len, input int start_w,
                            input int mode);
    bit ok;
    issue_cmd(1'b0, addr, len, ok);
    if (ok) collect_read(start_w, len, mode);
  endtask

  // Both commands valid together; exp_w says which one must win the tie.
  task automatic tie_case(input int wr_word, input int rd_word, input bit exp_w);
    logic [511:0] d;
    d = rand_beat();
    @(negedge clk);
    i_wcmd_valid = 1'b1; i_wcmd_addr = 32'(wr_word * 64); i_wcmd_len = 6'd0;
    i_rcmd_valid = 1'b1; i_rcmd_addr = 32'(rd_word * 64); i_rcmd_len = 6'd0;
    #1;
    check1("tie_wcmd_ready", o_wcmd_ready, exp_w);
    check1("tie_rcmd_ready", o_rcmd_ready, !exp_w);
    @(posedge clk);
    #1;
    if (exp_w) begin
      i_wcmd_valid = 1'b0;
      check1("busy_rcmd_ready", o_rcmd_ready, 1'b0);
      i_wvalid = 1'b1;
      i_wdata  = d;
      @(posedge clk);
      #1;
      i_wvalid = 1'b0;
      mem_m[widx(wr_word)] = d;
      wr_cnt_m++;
      check1("second_rcmd_ready", o_rcmd_ready, 1'b1);
      @(posedge clk);
      #1;
      i_rcmd_valid = 1'b0;
      collect_read(rd_word, 6'd0, 0);
    end else begin
      i_rcmd_valid = 1'b0;
      check1("busy_wcmd_ready", o_wcmd_ready, 1'b0);
      collect_read(rd_word, 6'd0, 0);
      #1;
      check1("second_wcmd_ready", o_wcmd_ready, 1'b1);
      @(posedge clk);
      #1;
      i_wcmd_valid = 1'b0;
      i_wvalid = 1'b1;
      i_wdata  = d;
      @(posedge clk);
      #1;
      i_wvalid = 1'b0;
      mem_m[widx(wr_word)] = d;
      wr_cnt_m++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [511:0] d;
    logic [31:0]  ra;
    logic [5:0]   rl;

    tbl[0] = '{addr: 32'hdeadbeef, len: 6'd0,  pat: 32'hdeadbee0, exp_word: 59};
    tbl[1] = '{addr: 32'h00000FC0, len: 6'd3,  pat: 32'h00000000, exp_word: 63};
    tbl[2] = '{addr: 32'h12345678, len: 6'd5,  pat: 32'hA5A50000, exp_word: 25};
    tbl[3] = '{addr: 32'hFFFFF03F, len: 6'd1,  pat: 32'h0BADF00D, exp_word: 0};
    tbl[4] = '{addr: 32'h00000800, len: 6'd63, pat: 32'h55AA0100, exp_word: 32};

    i_rst = 1'b1;
    i_wcmd_valid = 1'b0; i_wcmd_addr = '0; i_wcmd_len = '0;
    i_rcmd_valid = 1'b0; i_rcmd_addr = '0; i_rcmd_len = '0;
    i_wvalid = 1'b0; i_wdata = '0; i_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("reset_wcmd_ready", o_wcmd_ready, 1'b0);
    check1("reset_rcmd_ready", o_rcmd_ready, 1'b0);
    check1("reset_wready", o_wready, 1'b0);
    check1("reset_rvalid", o_rvalid, 1'b0);
    checkw("reset_rdata", o_rdata, '0);
    i_rst = 1'b0;

    // Fill the whole memory so every model word is known, then read it back.
    write_burst(32'h0, 6'd63, 0, 1'b1, 32'h0, 1'b0);
    read_burst(32'h0, 6'd63, 0, 0);

    // Address mapping / wrap table: write at the given address, read back
    // from the canonical address of the expected start word.
    for (int v = 0; v < 5; v++) begin
      write_burst(tbl[v].addr, tbl[v].len, tbl[v].exp_word, 1'b0, tbl[v].pat, 1'b0);
      read_burst(32'(tbl[v].exp_word * 64), tbl[v].len, tbl[v].exp_word, 0);
    end

    // Read backpressure with a wrapping start word.
    read_burst(32'h00000FC0, 6'd2, 63, 2);

    // Write data without a command must be refused and must not land.
    @(negedge clk);
    i_wvalid = 1'b1;
    i_wdata  = {512{1'b1}};
    for (int n = 0; n < 3; n++) begin
      #1;
      check1("wready_idle", o_wready, 1'b0);
      @(negedge clk);
    end
    i_wvalid = 1'b0;
    read_burst(32'h0, 6'd63, 0, 0);

    // Round-robin ties from reset.
    pulse_reset();
    tie_case(10, 10, 1'b1);
    tie_case(11, 11, 1'b1);
    write_burst(32'(12 * 64), 6'd0, 12, 1'b1, 32'h0, 1'b0);
    tie_case(13, 12, 1'b0);

    // Reset in the middle of a write burst: only the first three beats land.
    issue_cmd(1'b1, 32'h0, 6'd7, ok);
    for (int i = 0; i < 3; i++) begin
      d = rand_beat();
      i_wvalid = 1'b1;
      i_wdata  = d;
      @(posedge clk);
      #1;
      mem_m[widx(i)] = d;
    end
    i_wdata = rand_beat();
    pulse_reset();
    i_wvalid = 1'b0;
    read_burst(32'h0, 6'd7, 0, 0);

    // Reset in the middle of a read burst: rvalid drops at once.
    issue_cmd(1'b0, 32'h0, 6'd5, ok);
    @(negedge clk);
    check1("mid_read_rvalid", o_rvalid, 1'b1);
    i_rready = 1'b1;
    @(posedge clk);
    #1;
    pulse_reset();
    i_rready = 1'b0;
    read_burst(32'h40, 6'd1, 1, 1);

    // Randomized traffic against the model.
    for (int t = 0; t < 30; t++) begin
      ra = $urandom;
      rl = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        write_burst(ra, rl, addr_word(ra), 1'b1, 32'h0, 1'b1);
      else
        read_burst(ra, rl, addr_word(ra), 1);
    end
    read_burst(32'h0, 6'd63, 0, 1);

`ifdef UMAI_MEM_RESPONDER_STATS_EN
    check32("wr_beat_cnt_model", o_wr_beat_cnt, 32'(wr_cnt_m));
    check32("rd_beat_cnt_model", o_rd_beat_cnt, 32'(rd_cnt_m));
    pulse_reset();
    check32("wr_beat_cnt_reset", o_wr_beat_cnt, 32'd0);
    check32("rd_beat_cnt_reset", o_rd_beat_cnt, 32'd0);
    write_burst(32'h0, 6'd3, 0, 1'b1, 32'h0, 1'b0);
    read_burst(32'h0, 6'd1, 0, 0);
    check32("wr_beat_cnt", o_wr_beat_cnt, 32'd4);
    check32("rd_beat_cnt", o_rd_beat_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
